// File: rtl/dut_response_cmp.sv
// rtl/dut_response_cmp.sv - per-pin strobed response capture and compare for the 128-pin tester
module dut_response_cmp #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PERFORM_TEST,
  input  logic [127:0]      BUS128,
  input  logic              EXP_LOAD,
  input  logic              EXP_TRANSFER,
  input  logic              MASK_LOAD,
  input  logic              MASK_TRANSFER,
  input  logic [127:0]      TEMPLATE_OUT,
  input  logic [7:0]        CYCLE_LENGTH,
  input  logic [6:0]        STROBE_EDGE,
  input  logic              CLEAR_RESULTS,
  input  logic [127:0]      DUT_PINS,
  output logic [127:0]      SAMPLE,
  output logic [127:0]      FAIL_VEC,
  output logic [127:0]      FAIL_STICKY,
  output logic [CNT_W-1:0]  FAIL_COUNT,
  output logic              FIRST_FAIL_VALID,
  output logic [CNT_W-1:0]  FIRST_FAIL_CYCLE,
  output logic [CNT_W-1:0]  CYCLE_INDEX,
  output logic              STROBE_DONE,
  output logic              CYCLE_END
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [7:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cycle_idx_q, cycle_idx_d;
  logic              wrap, strobe;

  logic [127:0]      sync_q [SYNC_STAGES];
  logic [127:0]      exp_pre_q, exp_act_q, mask_pre_q, mask_act_q;

  logic [127:0]      sample_q, cmp_q, fail_vec_q;
  logic [CNT_W-1:0]  strobe_idx_q;
  logic              commit_q, strobe_done_q;

  logic [127:0]      sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d, ffc_q, ffc_d;
  logic              ffv_q, ffv_d;

  // Sequencer next state: phase counting, cycle wrap and strobe detection.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cycle_idx_d = cycle_idx_q;
    wrap        = 1'b0;
    strobe      = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_d = 8'd0;
        if (PERFORM_TEST) begin
          state_d     = S_RUN;
          cycle_idx_d = '0;
        end
      end
      default: begin
        // CYCLE_LENGTH of 0 wraps at phase 255, i.e. a 256-clock cycle.
        wrap   = (phase_q == CYCLE_LENGTH - 8'd1);
        strobe = (phase_q == {1'b0, STROBE_EDGE});
        if (wrap) begin
          phase_d = 8'd0;
          if (cycle_idx_q != '1) cycle_idx_d = cycle_idx_q + CNT_W'(1);
        end else begin
          phase_d = phase_q + 8'd1;
        end
        if (!PERFORM_TEST) begin
          state_d = S_IDLE;
          phase_d = 8'd0;
        end
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      phase_q     <= 8'd0;
      cycle_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cycle_idx_q <= cycle_idx_d;
    end
  end

  // Pin synchronizer chain; the last stage is what the strobe compares.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= DUT_PINS;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Expected/mask double buffers; a transfer always moves the pre-load value seen before this edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      exp_pre_q  <= '0;
      exp_act_q  <= '0;
      mask_pre_q <= '0;
      mask_act_q <= '0;
    end else begin
      if (EXP_LOAD)      exp_pre_q  <= BUS128;
      if (EXP_TRANSFER)  exp_act_q  <= exp_pre_q;
      if (MASK_LOAD)     mask_pre_q <= BUS128;
      if (MASK_TRANSFER) mask_act_q <= mask_pre_q;
    end
  end

  // Strobe capture and one-clock-later commit of the per-pin compare.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_q      <= '0;
      cmp_q         <= '0;
      strobe_idx_q  <= '0;
      commit_q      <= 1'b0;
      fail_vec_q    <= '0;
      strobe_done_q <= 1'b0;
    end else begin
      commit_q      <= strobe;
      strobe_done_q <= commit_q;
      if (strobe) begin
        sample_q     <= sync_q[SYNC_STAGES-1];
        cmp_q        <= (sync_q[SYNC_STAGES-1] ^ exp_act_q) & mask_act_q & TEMPLATE_OUT;
        strobe_idx_q <= cycle_idx_q;
      end
      if (commit_q) fail_vec_q <= cmp_q;
    end
  end

  // Accumulated results; a clear overrides any commit landing on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    ffv_d    = ffv_q;
    ffc_d    = ffc_q;
    if (commit_q) begin
      sticky_d = sticky_q | cmp_q;
      if (|cmp_q) begin
        if (count_q != '1) count_d = count_q + CNT_W'(1);
        if (!ffv_q) begin
          ffv_d = 1'b1;
          ffc_d = strobe_idx_q;
        end
      end
    end
    if (CLEAR_RESULTS) begin
      sticky_d = '0;
      count_d  = '0;
      ffv_d    = 1'b0;
      ffc_d    = '0;
    end
  end

  // Result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sticky_q <= '0;
      count_q  <= '0;
      ffv_q    <= 1'b0;
      ffc_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
      ffv_q    <= ffv_d;
      ffc_q    <= ffc_d;
    end
  end

  assign SAMPLE           = sample_q;
  assign FAIL_VEC         = fail_vec_q;
  assign FAIL_STICKY      = sticky_q;
  assign FAIL_COUNT       = count_q;
  assign FIRST_FAIL_VALID = ffv_q;
  assign FIRST_FAIL_CYCLE = ffc_q;
  assign CYCLE_INDEX      = cycle_idx_q;
  assign STROBE_DONE      = strobe_done_q;
  assign CYCLE_END        = wrap;

endmodule

// File: tb/tb_dut_response_cmp.sv
// tb/tb_dut_response_cmp.sv - directed self-checking bench for dut_response_cmp
module tb_dut_response_cmp;

  localparam logic [127:0] ALL1 = '1;
  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] XV   = {16{8'h3C}};
  localparam logic [127:0] YV   = {16{8'hC3}};

  logic          CLK;
  logic          RST;
  logic          PERFORM_TEST;
  logic [127:0]  BUS128;
  logic          EXP_LOAD, EXP_TRANSFER, MASK_LOAD, MASK_TRANSFER;
  logic [127:0]  TEMPLATE_OUT;
  logic [7:0]    CYCLE_LENGTH;
  logic [6:0]    STROBE_EDGE;
  logic          CLEAR_RESULTS;
  logic [127:0]  DUT_PINS;
  logic [127:0]  SAMPLE, FAIL_VEC, FAIL_STICKY;
  logic [15:0]   FAIL_COUNT, FIRST_FAIL_CYCLE, CYCLE_INDEX;
  logic          FIRST_FAIL_VALID, STROBE_DONE, CYCLE_END;

  int errors = 0;
  int checks = 0;

  dut_response_cmp #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .PERFORM_TEST(PERFORM_TEST), .BUS128(BUS128),
    .EXP_LOAD(EXP_LOAD), .EXP_TRANSFER(EXP_TRANSFER),
    .MASK_LOAD(MASK_LOAD), .MASK_TRANSFER(MASK_TRANSFER),
    .TEMPLATE_OUT(TEMPLATE_OUT), .CYCLE_LENGTH(CYCLE_LENGTH), .STROBE_EDGE(STROBE_EDGE),
    .CLEAR_RESULTS(CLEAR_RESULTS), .DUT_PINS(DUT_PINS),
    .SAMPLE(SAMPLE), .FAIL_VEC(FAIL_VEC), .FAIL_STICKY(FAIL_STICKY),
    .FAIL_COUNT(FAIL_COUNT), .FIRST_FAIL_VALID(FIRST_FAIL_VALID),
    .FIRST_FAIL_CYCLE(FIRST_FAIL_CYCLE), .CYCLE_INDEX(CYCLE_INDEX),
    .STROBE_DONE(STROBE_DONE), .CYCLE_END(CYCLE_END)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_mask(input logic [127:0] v);
    BUS128 = v; MASK_LOAD = 1'b1; tick();
    MASK_LOAD = 1'b0; MASK_TRANSFER = 1'b1; tick();
    MASK_TRANSFER = 1'b0;
  endtask

  task automatic load_exp(input logic [127:0] v);
    BUS128 = v; EXP_LOAD = 1'b1; tick();
    EXP_LOAD = 1'b0; EXP_TRANSFER = 1'b1; tick();
    EXP_TRANSFER = 1'b0;
  endtask

  task automatic clear_results();
    CLEAR_RESULTS = 1'b1; tick();
    CLEAR_RESULTS = 1'b0;
  endtask

  task automatic stop_run();
    PERFORM_TEST = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (SAMPLE !== '0 || FAIL_VEC !== '0 || FAIL_STICKY !== '0 || FAIL_COUNT !== '0 ||
        FIRST_FAIL_VALID !== 1'b0 || FIRST_FAIL_CYCLE !== '0 || CYCLE_INDEX !== '0 ||
        STROBE_DONE !== 1'b0 || CYCLE_END !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs not zero: sample=%h fvec=%h sticky=%h cnt=%0d ffv=%b ffc=%0d idx=%0d done=%b end=%b required all 0",
               tag, SAMPLE, FAIL_VEC, FAIL_STICKY, FAIL_COUNT, FIRST_FAIL_VALID,
               FIRST_FAIL_CYCLE, CYCLE_INDEX, STROBE_DONE, CYCLE_END);
    end
  endtask

  task automatic test_reset();
    check_all_zero("reset_state");
  endtask

  task automatic test_match();
    logic exp_done;
    load_mask(ALL1); TEMPLATE_OUT = ALL1; load_exp(A5); DUT_PINS = A5;
    CYCLE_LENGTH = 8'd10; STROBE_EDGE = 7'd4;
    repeat (4) tick();
    clear_results();
    PERFORM_TEST = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      tick();
      exp_done = (i >= 7) && ((i - 7) % 10 == 0);
      checks++;
      if (STROBE_DONE !== exp_done) begin
        errors++;
        $display("FAIL match_done tick=%0d got=%b required=%b", i, STROBE_DONE, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (FAIL_VEC !== '0) begin
          errors++;
          $display("FAIL match_fvec tick=%0d got=%h required=0", i, FAIL_VEC);
        end
      end
    end
    checks++;
    if (FAIL_COUNT !== 16'd0) begin
      errors++;
      $display("FAIL match_count got=%0d required=0", FAIL_COUNT);
    end
    stop_run();
  endtask

  task automatic test_pin_flip();
    logic exp_done;
    logic [127:0] exp_fv;
    clear_results();
    PERFORM_TEST = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      tick();
      if (i == 31) DUT_PINS = A5 ^ 128'h80;
      if (i == 41) DUT_PINS = A5;
      exp_done = (i >= 7) && ((i - 7) % 10 == 0);
      exp_fv   = (i == 37) ? 128'h80 : 128'h0;
      checks++;
      if (STROBE_DONE !== exp_done) begin
        errors++;
        $display("FAIL flip_done tick=%0d got=%b required=%b", i, STROBE_DONE, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (FAIL_VEC !== exp_fv) begin
          errors++;
          $display("FAIL flip_fvec tick=%0d got=%h required=%h", i, FAIL_VEC, exp_fv);
        end
      end
    end
    checks++;
    if (FAIL_STICKY !== 128'h80) begin
      errors++; $display("FAIL flip_sticky got=%h required=%h", FAIL_STICKY, 128'h80);
    end
    checks++;
    if (FAIL_COUNT !== 16'd1) begin
      errors++; $display("FAIL flip_count got=%0d required=1", FAIL_COUNT);
    end
    checks++;
    if (FIRST_FAIL_VALID !== 1'b1 || FIRST_FAIL_CYCLE !== 16'd3) begin
      errors++;
      $display("FAIL flip_first got valid=%b cycle=%0d required valid=1 cycle=3",
               FIRST_FAIL_VALID, FIRST_FAIL_CYCLE);
    end
    stop_run();
  endtask

  task automatic test_masked();
    logic exp_done;
    load_mask(128'hFF); TEMPLATE_OUT = 128'h0F0F; DUT_PINS = ~A5;
    repeat (4) tick();
    clear_results();
    PERFORM_TEST = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_done = (i == 7) || (i == 17);
      if (exp_done) begin
        checks++;
        if (STROBE_DONE !== 1'b1 || FAIL_VEC !== 128'h0F) begin
          errors++;
          $display("FAIL masked_fvec tick=%0d got done=%b fvec=%h required done=1 fvec=%h",
                   i, STROBE_DONE, FAIL_VEC, 128'h0F);
        end
      end
    end
    checks++;
    if (FAIL_COUNT !== 16'd2 || FIRST_FAIL_VALID !== 1'b1 || FIRST_FAIL_CYCLE !== 16'd0) begin
      errors++;
      $display("FAIL masked_results got cnt=%0d ffv=%b ffc=%0d required cnt=2 ffv=1 ffc=0",
               FAIL_COUNT, FIRST_FAIL_VALID, FIRST_FAIL_CYCLE);
    end
    stop_run();
  endtask

  task automatic test_strobe_skip();
    logic exp_end;
    CYCLE_LENGTH = 8'd8; STROBE_EDGE = 7'd12;
    clear_results();
    PERFORM_TEST = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp_end = (i % 8 == 0);
      checks++;
      if (STROBE_DONE !== 1'b0 || CYCLE_END !== exp_end) begin
        errors++;
        $display("FAIL skip_tick tick=%0d got done=%b end=%b required done=0 end=%b",
                 i, STROBE_DONE, CYCLE_END, exp_end);
      end
    end
    checks++;
    if (CYCLE_INDEX !== 16'd3) begin
      errors++; $display("FAIL skip_index got=%0d required=3", CYCLE_INDEX);
    end
    stop_run();
    CYCLE_LENGTH = 8'd10; STROBE_EDGE = 7'd4;
  endtask

  task automatic test_clear_collide();
    clear_results();
    PERFORM_TEST = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      CLEAR_RESULTS = (i == 7);
      tick();
      if (i == 7) begin
        checks++;
        if (STROBE_DONE !== 1'b1 || FAIL_VEC !== 128'h0F) begin
          errors++;
          $display("FAIL collide_fvec got done=%b fvec=%h required done=1 fvec=%h",
                   STROBE_DONE, FAIL_VEC, 128'h0F);
        end
        checks++;
        if (FAIL_STICKY !== '0 || FAIL_COUNT !== '0 || FIRST_FAIL_VALID !== 1'b0 ||
            FIRST_FAIL_CYCLE !== '0) begin
          errors++;
          $display("FAIL collide_results got sticky=%h cnt=%0d ffv=%b ffc=%0d required all 0",
                   FAIL_STICKY, FAIL_COUNT, FIRST_FAIL_VALID, FIRST_FAIL_CYCLE);
        end
      end
    end
    CLEAR_RESULTS = 1'b0;
    stop_run();
  endtask

  task automatic test_load_transfer_and_reset();
    load_mask(ALL1); TEMPLATE_OUT = ALL1;
    load_exp(XV);
    BUS128 = YV; EXP_LOAD = 1'b1; EXP_TRANSFER = 1'b1; tick();
    EXP_LOAD = 1'b0; EXP_TRANSFER = 1'b0;
    DUT_PINS = XV;
    repeat (3) tick();
    clear_results();
    PERFORM_TEST = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      EXP_TRANSFER = (i == 9);
      tick();
      if (i == 7) begin
        checks++;
        if (STROBE_DONE !== 1'b1 || FAIL_VEC !== '0) begin
          errors++;
          $display("FAIL ldxfer_old_pre got done=%b fvec=%h required done=1 fvec=0",
                   STROBE_DONE, FAIL_VEC);
        end
      end
      if (i == 17) begin
        checks++;
        if (STROBE_DONE !== 1'b1 || FAIL_VEC !== (XV ^ YV) || FAIL_STICKY !== (XV ^ YV)) begin
          errors++;
          $display("FAIL ldxfer_new_act got done=%b fvec=%h sticky=%h required done=1 both=%h",
                   STROBE_DONE, FAIL_VEC, FAIL_STICKY, XV ^ YV);
        end
      end
    end
    EXP_TRANSFER = 1'b0;
    RST = 1'b1; PERFORM_TEST = 1'b0;
    tick();
    check_all_zero("midrun_reset");
    RST = 1'b0;
    tick();
    check_all_zero("after_reset");
  endtask

  initial begin
    RST = 1'b1; PERFORM_TEST = 1'b0; BUS128 = '0;
    EXP_LOAD = 1'b0; EXP_TRANSFER = 1'b0; MASK_LOAD = 1'b0; MASK_TRANSFER = 1'b0;
    TEMPLATE_OUT = '0; CYCLE_LENGTH = 8'd10; STROBE_EDGE = 7'd4;
    CLEAR_RESULTS = 1'b0; DUT_PINS = '0;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    test_reset();
    test_match();
    test_pin_flip();
    test_masked();
    test_strobe_skip();
    test_clear_collide();
    test_load_transfer_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dut_response_cmp.md
# dut_response_cmp

Per-pin response capture and compare block for the 128-pin ASIC tester: the receive-side counterpart of the drive/format/tristate path. It samples the DUT pins at a programmable strobe point in every tester cycle and compares them against a double-buffered expected-value vector. Only pins that are not driven by the tester and are enabled in a compare mask are checked. It accumulates per-pin sticky fail flags, a failing-vector count and the index of the first failing cycle for host readback.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on DUT_PINS (minimum 2)
- CNT_W, 16, width of CYCLE_INDEX, FAIL_COUNT and FIRST_FAIL_CYCLE

Ports:
- CLK  in  1  system clock; the block uses this single clock only
- RST  in  1  synchronous, active-high reset
- PERFORM_TEST  in  1  level; 1 = run compare sequencing
- BUS128  in  128  host data bus for expected and mask loads
- EXP_LOAD / EXP_TRANSFER  in  1 each  expected pre-buffer load; pre-buffer to active copy
- MASK_LOAD / MASK_TRANSFER  in  1 each  compare-mask pre-buffer load; pre-buffer to active copy
- TEMPLATE_OUT  in  128  tester tristate enable-bar per pin; 1 = tester not driving, so the pin is comparable
- CYCLE_LENGTH  in  8  tester cycle length in CLK periods; 0 means 256
- STROBE_EDGE  in  7  phase within the tester cycle at which pins are sampled
- CLEAR_RESULTS  in  1  pulse; clears sticky, count and first-fail results
- DUT_PINS  in  128  asynchronous DUT pin levels
- SAMPLE  out  128  pin values captured at the last strobe
- FAIL_VEC  out  128  per-pin fail result of the last strobe
- FAIL_STICKY  out  128  OR of all FAIL_VEC since the last clear
- FAIL_COUNT  out  CNT_W  number of strobes with at least one failing pin; saturating
- FIRST_FAIL_VALID  out  1  set on the first failing strobe since the last clear
- FIRST_FAIL_CYCLE  out  CNT_W  CYCLE_INDEX of the first failing strobe
- CYCLE_INDEX  out  CNT_W  tester cycles completed in the current run; saturating
- STROBE_DONE  out  1  one-cycle pulse; compare results updated this cycle
- CYCLE_END  out  1  one-cycle pulse on the last phase of each tester cycle

## Operation
- FSM with two states, IDLE and RUN.
  - IDLE to RUN when PERFORM_TEST=1. Entry clears phase and CYCLE_INDEX.
  - RUN to IDLE when PERFORM_TEST=0. Phase is held at 0, and no new strobes occur.
- Phase counter (8 bit), RUN only:
  - Increments each CLK.
  - At phase == CYCLE_LENGTH-1 (mod 256) it wraps to 0, pulses CYCLE_END, and increments CYCLE_INDEX, which saturates at all-ones.
- Strobe rule: a strobe occurs in RUN when phase == {0,STROBE_EDGE}.
  - If STROBE_EDGE ≥ effective cycle length, no strobe occurs in that cycle. This is not an error.
  - At the strobe edge: SAMPLE <= synchronized pins, and cmp <= (sync ^ exp_active) & mask_active & TEMPLATE_OUT.
- Result commit occurs on the edge after the strobe. Signals update as follows:
  - FAIL_VEC <= cmp, and STROBE_DONE=1.
  - FAIL_STICKY |= cmp.
  - If |cmp, FAIL_COUNT increments (saturating at all-ones). If FIRST_FAIL_VALID=0, FIRST_FAIL_CYCLE <= CYCLE_INDEX value at the strobe, and FIRST_FAIL_VALID <= 1.
- A commit pending when PERFORM_TEST falls still completes.
- Double buffers (expected, mask):
  - LOAD: pre <= BUS128.
  - TRANSFER: active <= pre.
  - LOAD and TRANSFER in the same cycle: active gets the old pre, and pre gets BUS128.
  - TRANSFER on a strobe edge: the compare uses the active value from before the transfer.
- CLEAR_RESULTS clears FAIL_STICKY, FAIL_COUNT, FIRST_FAIL_VALID and FIRST_FAIL_CYCLE. If it coincides with a commit, the clear wins and that commit is discarded except for FAIL_VEC and STROBE_DONE. It does not touch SAMPLE, CYCLE_INDEX or the buffers.
- Reset: all outputs, buffers, synchronizers and counters go to 0, and the FSM goes to IDLE.

## Timing
- Pin to comparable latency is SYNC_STAGES CLKs. Pins must be stable ≥ SYNC_STAGES+1 CLKs before the strobe edge.
- RUN entry: the first phase-0 cycle is the CLK after PERFORM_TEST is first seen as 1.
- STROBE_DONE occurs exactly 1 CLK after the strobe edge. Across consecutive tester cycles, the spacing is CYCLE_LENGTH CLKs.
- RST asserted mid-run aborts the run and any pending commit in the same edge.
- CYCLE_LENGTH and STROBE_EDGE are sampled live. Changing them mid-run takes effect on the next compare.

## Test plan
- Mask all ones, template all ones, expected 0xA5..A5, pins driven to 0xA5..A5, CYCLE_LENGTH=10, STROBE_EDGE=4. Expected: STROBE_DONE every 10 CLKs, FAIL_VEC=0, and FAIL_COUNT stays 0.
- Same setup with pin 7 flipped in cycle 3 only. Expected:
  - FAIL_VEC bit 7 set on that commit only.
  - FAIL_STICKY bit 7 remains set.
  - FAIL_COUNT=1, FIRST_FAIL_CYCLE=3 and FIRST_FAIL_VALID=1.
- All pins mismatching with mask=0x0..0FF and template=0x0..0F0F. Expected: FAIL_VEC=0x0..00F per strobe.
- STROBE_EDGE=12 with CYCLE_LENGTH=8. Expected: no STROBE_DONE, CYCLE_END every 8 CLKs, and CYCLE_INDEX increments.
- Failing strobe commit coincident with CLEAR_RESULTS. Expected: FAIL_VEC reflects the fail, while sticky, count and first-fail all read 0.
- EXP_LOAD and EXP_TRANSFER in the same cycle, followed by a strobe. Expected: the compare uses the previous pre-buffer value. Also pulse RST mid-run and check that every output is 0 on the next CLK.
